// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the pipeline.
// Owns the 16x16 register file (two combinational read ports with
// write-through bypass), resolves jumps into a redirect plus squash window,
// emits a print pulse on writes to r0, counts retired instructions and halts
// on illegal opcodes.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   x2_valid/ins/pc/result beat from the execute unit's x2 stage
//   rd_addr_1/2, rd_data_1/2  operand read ports (data is combinational)
//   redirect_valid/pc     one-cycle fetch restart request
//   print_valid/data      one-cycle character output on a write to r0
//   halted                sticky halt flag
//   retired_count         retired-instruction counter (wraps)
module wb_stage #(
  parameter int unsigned N_SQUASH = 3,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x2_valid,
  input  logic [15:0]      x2_ins,
  input  logic [15:0]      x2_pc,
  input  logic [15:0]      x2_result,
  input  logic [3:0]       rd_addr_1,
  input  logic [3:0]       rd_addr_2,
  output logic [15:0]      rd_data_1,
  output logic [15:0]      rd_data_2,
  output logic             redirect_valid,
  output logic [15:0]      redirect_pc,
  output logic             print_valid,
  output logic [7:0]       print_data,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
);

  localparam int unsigned SQ_W = (N_SQUASH > 0) ? $clog2(N_SQUASH + 1) : 1;

  typedef enum logic [1:0] {RUN, SQUASH, HALTED} state_t;

  state_t            state, state_d;
  logic [SQ_W-1:0]   sq_cnt, sq_cnt_d;
  logic [15:0]       regs [16];

  logic              redirect_valid_d, print_valid_d, halted_d;
  logic [15:0]       redirect_pc_d;
  logic [7:0]        print_data_d;
  logic [CNT_W-1:0]  count_d;

  logic [3:0]        op, sub, rt;
  logic              cls_write, cls_jump, cls_illegal;
  logic              accept, wr_en, jump_taken;

  // ra field is not needed at writeback
  logic              unused_ra;
  assign unused_ra = ^x2_ins[11:8];

  assign op  = x2_ins[15:12];
  assign sub = x2_ins[7:4];
  assign rt  = x2_ins[3:0];

  // Instruction class decode; memory ops fall through as plain retires
  always_comb begin
    cls_write   = 1'b0;
    cls_jump    = 1'b0;
    cls_illegal = 1'b0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'hE: cls_write = 1'b1;
      4'h6: begin
        if (sub <= 4'd3) cls_jump = 1'b1;
        else             cls_illegal = 1'b1;
      end
      4'h4, 4'hC, 4'hD: ;
      default: cls_illegal = 1'b1;
    endcase
  end

  assign accept     = (state == RUN) && x2_valid;
  assign wr_en      = accept && cls_write && (rt != 4'd0);
  assign jump_taken = accept && cls_jump && (x2_result != (x2_pc + 16'd2));

  // Read port with write-through bypass; r0 is hardwired to zero
  function automatic logic [15:0] read_port(input logic [3:0] addr);
    if (addr == 4'd0)                return 16'd0;
    else if (wr_en && (addr == rt))  return x2_result;
    else                             return regs[addr];
  endfunction

  assign rd_data_1 = read_port(rd_addr_1);
  assign rd_data_2 = read_port(rd_addr_2);

  // Next-state and registered-output logic
  always_comb begin
    state_d          = state;
    sq_cnt_d         = sq_cnt;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc;
    print_valid_d    = 1'b0;
    print_data_d     = print_data;
    halted_d         = halted;
    count_d          = retired_count;
    case (state)
      RUN: begin
        if (x2_valid) begin
          if (cls_illegal) begin
            halted_d = 1'b1;
            state_d  = HALTED;
          end else begin
            count_d = retired_count + CNT_W'(1);
            if (cls_write && (rt == 4'd0)) begin
              print_valid_d = 1'b1;
              print_data_d  = x2_result[7:0];
            end
            if (jump_taken) begin
              redirect_valid_d = 1'b1;
              redirect_pc_d    = x2_result;
              sq_cnt_d         = SQ_W'(N_SQUASH);
              state_d          = (N_SQUASH == 0) ? RUN : SQUASH;
            end
          end
        end
      end
      SQUASH: begin
        // Only real beats consume the squash window
        if (x2_valid) begin
          sq_cnt_d = sq_cnt - SQ_W'(1);
          if (sq_cnt <= SQ_W'(1)) state_d = RUN;
        end
      end
      HALTED: ;
      default: state_d = RUN;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      sq_cnt         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 16'd0;
      print_valid    <= 1'b0;
      print_data     <= 8'd0;
      halted         <= 1'b0;
      retired_count  <= '0;
    end else begin
      state          <= state_d;
      sq_cnt         <= sq_cnt_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
      print_valid    <= print_valid_d;
      print_data     <= print_data_d;
      halted         <= halted_d;
      retired_count  <= count_d;
    end
  end

  // Register file storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 16'd0;
    end else if (wr_en) begin
      regs[rt] <= x2_result;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a driver applies directed and random beats
// to a behavioural model and queues the expected responses; monitors compare
// read data each cycle, status after each edge, and redirect/print pulses.
module tb_wb_stage;
  localparam int unsigned N_SQ = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        x2_valid;
  logic [15:0] x2_ins, x2_pc, x2_result;
  logic [3:0]  rd_addr_1, rd_addr_2;
  logic [15:0] rd_data_1, rd_data_2;
  logic        redirect_valid, print_valid, halted;
  logic [15:0] redirect_pc;
  logic [7:0]  print_data;
  logic [31:0] retired_count;

  wb_stage #(.N_SQUASH(N_SQ), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .x2_valid(x2_valid), .x2_ins(x2_ins),
    .x2_pc(x2_pc), .x2_result(x2_result),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .print_valid(print_valid), .print_data(print_data),
    .halted(halted), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic halted; logic [31:0] count;} status_t;

  logic [15:0] redir_q [$];
  logic [7:0]  print_q [$];
  logic [31:0] rd_q    [$];
  status_t     status_q[$];

  // Behavioural model of the architectural state
  logic [15:0] m_regs [16];
  logic [31:0] m_count;
  bit          m_halt;
  int          m_squash;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] wr_ops  [6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'hE};
  logic [3:0] mem_ops [3] = '{4'h4, 4'hC, 4'hD};
  logic [3:0] ill_ops [6] = '{4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'hF};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit is_write_op(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'hE};
  endfunction

  function automatic logic [15:0] model_read(input logic [3:0] a, input bit wr,
                                             input logic [3:0] rt, input logic [15:0] res);
    if (a == 4'd0) return 16'd0;
    if (wr && a == rt) return res;
    return m_regs[a];
  endfunction

  // One clock of stimulus plus the model's view of that clock edge
  task automatic cycle(input bit r, input bit v, input logic [15:0] ins,
                       input logic [15:0] pc, input logic [15:0] res,
                       input logic [3:0] a1, input logic [3:0] a2);
    logic [3:0] op, sub, rt;
    bit live, wr;
    @(negedge clk);
    rst = r; x2_valid = v && !r; x2_ins = ins; x2_pc = pc; x2_result = res;
    rd_addr_1 = a1; rd_addr_2 = a2;
    op = ins[15:12]; sub = ins[7:4]; rt = ins[3:0];
    live = x2_valid && !m_halt && (m_squash == 0);
    wr = live && is_write_op(op) && (rt != 4'd0);
    rd_q.push_back({model_read(a1, wr, rt, res), model_read(a2, wr, rt, res)});
    if (r) begin
      foreach (m_regs[i]) m_regs[i] = 16'd0;
      m_count = 0; m_halt = 0; m_squash = 0;
    end else if (x2_valid && !m_halt) begin
      if (m_squash > 0) begin
        m_squash--;
      end else if (is_write_op(op)) begin
        m_count++;
        if (rt == 4'd0) print_q.push_back(res[7:0]);
        else m_regs[rt] = res;
      end else if (op == 4'h6 && sub <= 4'd3) begin
        m_count++;
        if (res != 16'(pc + 16'd2)) begin
          redir_q.push_back(res);
          m_squash = N_SQ;
        end
      end else if (op inside {4'h4, 4'hC, 4'hD}) begin
        m_count++;
      end else begin
        m_halt = 1;
      end
    end
    status_q.push_back('{halted: m_halt, count: m_count});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 16'h0, 16'h0, 16'h0, 4'($urandom), 4'($urandom));
  endtask

  // Monitor: combinational read ports, sampled mid-cycle
  initial forever begin
    logic [31:0] e;
    @(negedge clk); #2;
    if (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      chk("rd_data_1", {16'd0, rd_data_1}, {16'd0, e[31:16]});
      chk("rd_data_2", {16'd0, rd_data_2}, {16'd0, e[15:0]});
    end
  end

  // Monitor: registered outputs after each edge
  initial forever begin
    status_t s;
    @(posedge clk); #1;
    if (status_q.size() > 0) begin
      s = status_q.pop_front();
      chk("halted", {31'd0, halted}, {31'd0, s.halted});
      chk("retired_count", retired_count, s.count);
    end
    if (redirect_valid === 1'b1) begin
      if (redir_q.size() == 0) chk("redirect_spurious", 32'd1, 32'd0);
      else chk("redirect_pc", {16'd0, redirect_pc}, {16'd0, redir_q.pop_front()});
    end
    if (print_valid === 1'b1) begin
      if (print_q.size() == 0) chk("print_spurious", 32'd1, 32'd0);
      else chk("print_data", {24'd0, print_data}, {24'd0, print_q.pop_front()});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op, sub;
    logic [15:0] pc, res;
    rst = 1; x2_valid = 0; x2_ins = 0; x2_pc = 0; x2_result = 0;
    rd_addr_1 = 0; rd_addr_2 = 0;
    foreach (m_regs[i]) m_regs[i] = 16'd0;
    m_count = 0; m_halt = 0; m_squash = 0;

    cycle(1, 0, 16'h0, 16'h0, 16'h0, 4'd5, 4'd3);
    cycle(1, 0, 16'h0, 16'h0, 16'h0, 4'd5, 4'd3);
    // Basic write then read-back; bypass; r0 print
    cycle(0, 1, 16'h0005, 16'h0000, 16'h1234, 4'd5, 4'd0);
    cycle(0, 1, 16'h0003, 16'h0002, 16'hBEEF, 4'd5, 4'd3);
    cycle(0, 1, 16'h0000, 16'h0004, 16'h0041, 4'd0, 4'd3);
    idle(1);
    // Taken jump: three valid beats squashed with bubbles, fourth writes
    cycle(0, 1, 16'h6000, 16'h0010, 16'h0040, 4'd7, 4'd5);
    cycle(0, 1, 16'h0007, 16'h0040, 16'h1111, 4'd7, 4'd5);
    cycle(0, 0, 16'h0007, 16'h0042, 16'h2222, 4'd7, 4'd5);
    cycle(0, 1, 16'h0007, 16'h0042, 16'h3333, 4'd7, 4'd5);
    cycle(0, 0, 16'h0007, 16'h0044, 16'h4444, 4'd7, 4'd5);
    cycle(0, 1, 16'h0007, 16'h0044, 16'h5555, 4'd7, 4'd5);
    cycle(0, 1, 16'h0007, 16'h0046, 16'h6666, 4'd7, 4'd5);
    idle(1);
    // Not-taken jumps, including the PC wrap case
    cycle(0, 1, 16'h6000, 16'h0010, 16'h0012, 4'd7, 4'd3);
    cycle(0, 1, 16'h6300, 16'hFFFE, 16'h0000, 4'd7, 4'd3);
    cycle(0, 1, 16'h4000, 16'h0000, 16'h0002, 4'd7, 4'd3);
    // Illegal inside squash window is dropped, no halt
    cycle(0, 1, 16'h6100, 16'h0020, 16'h0080, 4'd7, 4'd3);
    cycle(0, 1, 16'hF000, 16'h0080, 16'h0000, 4'd7, 4'd3);
    cycle(0, 1, 16'h0007, 16'h0082, 16'h7777, 4'd7, 4'd3);
    cycle(0, 1, 16'h0007, 16'h0084, 16'h8888, 4'd7, 4'd3);
    cycle(0, 1, 16'h0008, 16'h0086, 16'h9999, 4'd8, 4'd7);
    // Reset mid-squash, then a write lands
    cycle(0, 1, 16'h6000, 16'h0030, 16'h0100, 4'd8, 4'd7);
    cycle(1, 0, 16'h0000, 16'h0000, 16'h0000, 4'd8, 4'd7);
    cycle(0, 1, 16'h0009, 16'h0000, 16'hABCD, 4'd9, 4'd8);
    // Illegal halts; later adds ignored; reset recovers
    cycle(0, 1, 16'hF000, 16'h0002, 16'h0000, 4'd9, 4'd8);
    cycle(0, 1, 16'h000A, 16'h0004, 16'h1357, 4'd10, 4'd9);
    cycle(0, 1, 16'h000A, 16'h0006, 16'h2468, 4'd10, 4'd9);
    cycle(1, 0, 16'h0000, 16'h0000, 16'h0000, 4'd10, 4'd9);
    cycle(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'd9, 4'd5);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int k;
      bit r, v;
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 3) != 0);
      k = $urandom_range(0, 19);
      pc = 16'($urandom) & 16'hFFFE;
      res = 16'($urandom);
      sub = 4'($urandom);
      if (k < 11)      op = wr_ops[$urandom_range(0, 5)];
      else if (k < 16) begin
        op = 4'h6;
        sub = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0) res = 16'(pc + 16'd2);
        if (pc == 16'hFFFE && $urandom_range(0, 1) == 0) res = 16'h0000;
      end
      else if (k < 19) op = mem_ops[$urandom_range(0, 2)];
      else             op = ill_ops[$urandom_range(0, 5)];
      cycle(r, v, {op, 4'($urandom), sub, 4'($urandom)}, pc, res,
            4'($urandom), 4'($urandom));
    end

    idle(2);
    @(posedge clk); #3;
    chk("redirect_drained", 32'(redir_q.size()), 32'd0);
    chk("print_drained", 32'(print_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final (writeback) pipeline stage. Sits directly downstream of the two-stage execute unit and consumes its x2 result together with the instruction and PC that accompany it.
- Owns the 16x16 architectural register file. Serves both operand read ports of the fetch/read stage, with write-through bypass.
- Resolves jumps into a PC redirect plus a squash window.
- Drives character output on writes to r0.
- Detects illegal opcodes and halts.

Parameters:
- N_SQUASH, 3, number of valid beats dropped after a taken redirect (the wrong-path instructions in the fr/x/x2 stages).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- x2_valid  in  1  the x2 beat holds a real instruction.
- x2_ins  in  16  instruction. Fields: opcode [15:12], ra [11:8], rb/subcode [7:4], rt [3:0].
- x2_pc  in  16  PC of the instruction.
- x2_result  in  16  result from execute. For a jump this is the next PC.
- rd_addr_1  in  4  read port 1 address.
- rd_addr_2  in  4  read port 2 address.
- rd_data_1  out  16  read port 1 data (combinational).
- rd_data_2  out  16  read port 2 data (combinational).
- redirect_valid  out  1  one-cycle pulse: fetch must restart at redirect_pc.
- redirect_pc  out  16  redirect target.
- print_valid  out  1  one-cycle pulse on a write to r0.
- print_data  out  8  low byte of the value written to r0.
- halted  out  1  sticky halt flag.
- retired_count  out  CNT_W  count of retired instructions.

Behaviour:
Reset (synchronous, rst high at posedge):
- All 16 registers cleared to 0.
- State = RUN; squash counter = 0.
- redirect_valid = 0, redirect_pc = 0, print_valid = 0, print_data = 0, halted = 0, retired_count = 0.
- A reset asserted mid-squash or while halted returns the block to RUN immediately.

Instruction classes (evaluated only when the beat is accepted):
- Register write of x2_result to rt: opcodes 0000 add, 0001 sub, 0010 mul, 0011 div, 0111 ld, 1110 dot-mul.
- Jump: opcode 0110 with subcode 0-3. No register write.
- Memory ops: opcodes 0100, 1100, 1101. No register write; they retire normally.
- Illegal: opcodes 0101, 1000-1011, 1111, and opcode 0110 with subcode > 3.

Register file:
- Reads of r0 always return 0.
- Reads are combinational.
- If a read address equals rt of an accepted write in the same cycle, the port returns x2_result (write-through bypass), except that r0 still reads 0.
- A write takes effect at the posedge of the accepted beat.

r0 writes:
- Do not modify storage.
- Set print_valid = 1 and print_data = x2_result[7:0] in the following cycle, for exactly one cycle.

State machine (RUN, SQUASH, HALTED):
- RUN: a beat is accepted when x2_valid = 1. Effects at the edge:
  - Register write, if the class writes.
  - retired_count + 1, for any accepted instruction that is not illegal.
  - Jump: taken when x2_result != x2_pc + 2 (16-bit wrap, so 0xFFFE + 2 = 0x0000). A taken jump sets redirect_valid = 1 and redirect_pc = x2_result for one cycle, loads the squash counter with N_SQUASH, and moves to SQUASH. A not-taken jump just retires.
  - Illegal: no write, no count; halted = 1; move to HALTED.
- SQUASH: each x2_valid beat is dropped (no write, no print, no count, no redirect) and decrements the counter. When the counter reaches 0, move to RUN. Cycles with x2_valid = 0 do not decrement.
- HALTED: all beats ignored. halted stays 1 until rst.

Other rules:
- redirect_valid, print_valid and halted are registered: they appear 1 cycle after the accepting edge.
- retired_count wraps modulo 2^CNT_W.
- An illegal instruction arriving while in SQUASH is squashed and does not halt.

Test Plan:
- Reset, then add with rt = 5 and x2_result = 0x1234 -> the following cycle rd_addr_1 = 5 gives 0x1234; retired_count = 1.
- Same-cycle bypass: write r3 = 0xBEEF while rd_addr_2 = 3 -> rd_data_2 = 0xBEEF in that cycle. Write r0 = 0x0041 -> rd_data of r0 = 0; next cycle print_valid = 1 with print_data = 0x41.
- Taken jump: pc = 0x0010, result = 0x0040 -> next cycle redirect_valid = 1, redirect_pc = 0x0040. The next 3 valid adds (with a bubble inserted between them) leave registers and count unchanged; the 4th add writes.
- Not-taken jump: pc = 0x0010, result = 0x0012 -> no redirect, count + 1. Wrap case: pc = 0xFFFE, result = 0x0000 -> not taken.
- Illegal opcode 0xF000 -> halted = 1 the next cycle; subsequent adds do not write or count. Then rst -> halted = 0, registers = 0, count = 0.
- Illegal opcode during SQUASH -> no halt. Reset asserted during SQUASH -> the next valid add writes normally.
